// File: rtl/lc3b_regfile_sb.sv
// Register file with byte-masked writes, write-to-read bypass, and a per-register
// saturating reservation counter acting as a scoreboard for multi-cycle results.
module lc3b_regfile_sb #(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 8,
   parameter int NUM_RD   = 2,
   parameter int PEND_W   = 2
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   rd_addr,
   output logic [NUM_RD*WIDTH-1:0]              rd_data,
   output logic [NUM_RD-1:0]                    rd_busy,
   input  logic                                 wr_en,
   input  logic [$clog2(NUM_REGS)-1:0]          wr_addr,
   input  logic [WIDTH-1:0]                     wr_data,
   input  logic [WIDTH/8-1:0]                   wr_mask,
   input  logic                                 rsv_en,
   input  logic [$clog2(NUM_REGS)-1:0]          rsv_addr,
   output logic [NUM_REGS-1:0]                  busy,
   output logic                                 err
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int NB = WIDTH / 8;
   localparam logic [PEND_W-1:0] MAXP = {PEND_W{1'b1}};

   logic [WIDTH-1:0]  r_data [NUM_REGS];
   logic [PEND_W-1:0] r_cnt  [NUM_REGS];
   logic              r_err;

   logic [WIDTH-1:0]    w_wr_merged;
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;

   // The merged word serves both the register update and the read bypass.
   always_comb begin
      w_wr_merged = r_data[wr_addr];
      for (int k = 0; k < NB; k++) begin
         if (wr_mask[k]) w_wr_merged[8*k +: 8] = wr_data[8*k +: 8];
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_reg
         assign w_inc[g] = rsv_en && (rsv_addr == AW'(g));
         assign w_dec[g] = wr_en  && (wr_addr  == AW'(g));
         assign busy[g]  = (r_cnt[g] != '0);
      end
      for (g = 0; g < NUM_RD; g++) begin : g_rd
         logic [AW-1:0] w_ra;
         assign w_ra = rd_addr[g*AW +: AW];
         assign rd_data[g*WIDTH +: WIDTH] = (wr_en && (w_ra == wr_addr)) ? w_wr_merged : r_data[w_ra];
         assign rd_busy[g] = busy[w_ra];
      end
   endgenerate

   assign err = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_data[r] <= '0;
            r_cnt[r]  <= '0;
         end
         r_err <= 1'b0;
      end else begin
         if (wr_en) r_data[wr_addr] <= w_wr_merged;
         // A reserve and a writeback hitting the same register cancel out.
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_inc[r] && !w_dec[r]) begin
               if (r_cnt[r] == MAXP) r_err <= 1'b1;
               else                  r_cnt[r] <= r_cnt[r] + 1'b1;
            end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
               r_cnt[r] <= r_cnt[r] - 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/lc3b_regfile_sb.md
LC3B_REGFILE_SB -- requirements
Module: lc3b_regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning register data width in bits, a multiple of 8.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning register count, a power of 2 and at least 2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter PEND_W, default 2, meaning per-register pending-reservation counter width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NUM_RD*AW, meaning read port i address in slice i.
REQ-008 SHALL have port rd_data, output, NUM_RD*WIDTH, meaning read port i data in slice i.
REQ-009 SHALL have port rd_busy, output, NUM_RD, meaning the reservation count of the register addressed by port i is nonzero.
REQ-010 SHALL have port wr_en, input, 1, meaning write/writeback strobe.
REQ-011 SHALL have port wr_addr, input, AW, meaning write destination.
REQ-012 SHALL have port wr_data, input, WIDTH, meaning write data.
REQ-013 SHALL have port wr_mask, input, WIDTH/8, meaning byte enables, bit k covering bits 8k+7..8k.
REQ-014 SHALL have port rsv_en, input, 1, meaning reserve the destination of an issued multi-cycle instruction.
REQ-015 SHALL have port rsv_addr, input, AW, meaning the register to reserve.
REQ-016 SHALL have port busy, output, NUM_REGS, meaning bit r is set when register r's count is nonzero.
REQ-017 SHALL have port err, output, 1, meaning sticky flag for a reservation overflow.

Function
REQ-018 Reads SHALL be combinational, with zero latency from rd_addr to rd_data.
REQ-019 When wr_en is high and wr_addr equals rd_addr[i], rd_data[i] SHALL be the bypassed merge: bytes with wr_mask set come from wr_data, all other bytes come from the stored value.
REQ-020 On a clock edge with wr_en high, only the bytes of register wr_addr whose wr_mask bit is set SHALL update; wr_mask all-zero SHALL leave data unchanged.
REQ-021 Each register SHALL have a saturating PEND_W-bit counter, MAXP = 2^PEND_W - 1.
REQ-022 An edge with rsv_en high only SHALL increment count[rsv_addr] if below MAXP.
REQ-023 An edge with wr_en high only SHALL decrement count[wr_addr] if nonzero; a write to a register with count 0 SHALL update data and leave the count at 0.
REQ-024 When rsv_en and wr_en are high with rsv_addr equal to wr_addr, that count SHALL be unchanged, including at 0 and at MAXP; err SHALL NOT set in this case.
REQ-025 When rsv_en and wr_en are high with different addresses, the increment and the decrement SHALL each apply independently.
REQ-026 A reservation to a counter at MAXP, without a same-address write, SHALL leave the count at MAXP and set err.
REQ-027 err SHALL remain set until rst.
REQ-028 busy and rd_busy SHALL be combinational from the registered counts, reflecting only updates made at or before the last edge, with no bypass of the current cycle's rsv_en or wr_en.
REQ-029 rd_busy[i] SHALL equal busy[rd_addr[i]].

Reset
REQ-030 While rst is high, all registers SHALL be 0, all counts 0, busy 0, and err 0, asynchronously and independent of clk.
REQ-031 A write or reservation whose edge coincides with rst high SHALL be discarded.
REQ-032 After rst deasserts, the first rising edge SHALL perform normal updates.

Verification
REQ-033 SHALL test full write then read: after reset, write R3 = 0x1234 with mask 11; next cycle rd_addr[0]=3 -> rd_data[0]=0x1234.
REQ-034 SHALL test byte masking and bypass: with R3=0x1234, write 0xABCD to R3 with mask 01 -> rd_data shows 0x12CD in the same cycle; R3 holds 0x12CD after the edge.
REQ-035 SHALL test the scoreboard: reserve R5 twice -> busy=0x20 and count 2; two writebacks to R5 -> busy=0x00 only after the second edge.
REQ-036 SHALL test overflow: with PEND_W=2, reserve R1 four times -> count 3 and err=1 after the fourth edge; err holds until rst.
REQ-037 SHALL test simultaneous operations: rsv and wr on R2 with count 1 -> count stays 1 and R2 data updates; rsv R4 with wr R6 (count 1) -> R4 count 1 and R6 count 0.
REQ-038 SHALL test reset mid-operation: assert rst between clock edges with busy nonzero -> busy=0, err=0 and rd_data=0 immediately, without waiting for an edge.
